// File: rtl/instr_mem_loader_if.sv
// Bundle of the loader's control, program-stream and bank-write signals.
// slave  : seen from the loader (consumes requests/stream, drives bank writes).
// master : seen from the program source (drives requests/stream, observes writes).
interface instr_mem_loader_if #(
  parameter int IW = 9,
  parameter int AW = 8
);
  // load control
  logic          load_req;
  logic [1:0]    bank_sel;
  logic [AW:0]   prog_len;
  logic          abort;
  // program word stream
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready;
  // bank write port
  logic          mem_we;
  logic [1:0]    mem_bank;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;
  // status
  logic          busy;
  logic          done;
  logic          err;
  logic          start;

  modport slave (
    input  load_req, bank_sel, prog_len, abort, in_valid, in_data,
    output in_ready, mem_we, mem_bank, mem_addr, mem_wdata,
    output busy, done, err, start
  );

  modport master (
    output load_req, bank_sel, prog_len, abort, in_valid, in_data,
    input  in_ready, mem_we, mem_bank, mem_addr, mem_wdata,
    input  busy, done, err, start
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Streams a program of IW-bit words into consecutive addresses of one bank, then pulses done/start.
// Latency: each accepted word is written one cycle later; done/start two cycles after the last write issues.
// Backpressure: in_ready is high only in LOAD (and not during abort); words are never dropped or duplicated.
module instr_mem_loader #(
  parameter int          IW       = 9,
  parameter int          AW       = 8,
  parameter int unsigned NUM_PROG = 3
) (
  input logic              CLK,
  input logic              Reset,
  instr_mem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_FLUSH  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Largest legal program: a full bank (2**AW words).
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  state_t        state;
  state_t        state_nxt;

  // Latched load parameters; count is one bit wider than the address so a
  // full-bank load ends at the top address without wrapping.
  logic [1:0]    bank_q;
  logic [AW:0]   len_q;
  logic [AW:0]   count;

  // Registered bank-write port and error pulse.
  logic          we_q;
  logic [1:0]    wbank_q;
  logic [AW-1:0] waddr_q;
  logic [IW-1:0] wdata_q;
  logic          err_q;

  // Decoded per-cycle conditions.
  logic          req_bad;
  logic          req_ok;
  logic          rdy;
  logic          accept;
  logic          last_word;
  logic          busy_c;
  logic          finish_c;

  // Request validation and stream handshake decode.
  always_comb begin
    req_bad   = 1'b0;
    req_ok    = 1'b0;
    accept    = 1'b0;
    last_word = 1'b0;
    if (bus.load_req) begin
      req_bad = (bus.prog_len == '0) ||
                (bus.prog_len > LEN_MAX) ||
                (32'(bus.bank_sel) >= NUM_PROG);
      req_ok  = !req_bad;
    end
    accept    = rdy && bus.in_valid;
    last_word = (count == (len_q - ONE));
  end

  // State register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort only matters once a load is under way.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_ok) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else if (accept && last_word) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore outputs; in_ready is gated by abort so no word slips in while cancelling.
  always_comb begin
    rdy      = 1'b0;
    busy_c   = 1'b0;
    finish_c = 1'b0;
    case (state)
      S_LOAD: begin
        rdy    = !bus.abort;
        busy_c = 1'b1;
      end
      S_FLUSH: begin
        busy_c = 1'b1;
      end
      S_FINISH: begin
        finish_c = 1'b1;
      end
      default: begin
        rdy = 1'b0;
      end
    endcase
  end

  // Load parameters and word count; the count restarts on every accepted request.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      bank_q <= '0;
      len_q  <= '0;
      count  <= '0;
    end else begin
      if (state == S_IDLE && req_ok) begin
        bank_q <= bus.bank_sel;
        len_q  <= bus.prog_len;
        count  <= '0;
      end else if (accept) begin
        count <= count + ONE;
      end
    end
  end

  // Bank write port: one registered write per accepted word; address/data hold between writes.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      we_q    <= 1'b0;
      wbank_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= accept;
      if (accept) begin
        wbank_q <= bank_q;
        waddr_q <= count[AW-1:0];
        wdata_q <= bus.in_data;
      end
    end
  end

  // Rejected requests raise a one-cycle error pulse; requests outside IDLE are ignored.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && req_bad;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.mem_we    = we_q;
  assign bus.mem_bank  = wbank_q;
  assign bus.mem_addr  = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_c;
  assign bus.done      = finish_c;
  assign bus.start     = finish_c;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: drives after rising edges, samples on falling edges.
// Every bank write is logged by a monitor and compared against hand-computed expectations.
// Ends with a single summary line.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  instr_mem_loader_if #(.IW(9), .AW(8)) bus ();

  instr_mem_loader dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: write log {bank[18:17], addr[16:9], data[8:0]} and pulse counters.
  logic [18:0] wr_q[$];
  int          wr_cyc[$];
  int          n_done = 0, n_start = 0, n_sd = 0, n_errp = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) begin
        wr_q.push_back({bus.mem_bank, bus.mem_addr, bus.mem_wdata});
        wr_cyc.push_back(cyc);
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.start) n_start++;
      if (bus.start != bus.done) n_sd++;
      if (bus.err) n_errp++;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wr_at(input int idx);
    if (idx < wr_q.size()) return {13'd0, wr_q[idx]};
    return 32'hxxxxxxxx;
  endfunction

  function automatic int cyc_at(input int idx);
    if (idx < wr_cyc.size()) return wr_cyc[idx];
    return -1000;
  endfunction

  logic [8:0] words[$];

  task automatic do_load(input logic [1:0] b, input logic [8:0] len, output int c0);
    @(posedge clk); #1;
    c0 = cyc;
    bus.load_req = 1'b1;
    bus.bank_sel = b;
    bus.prog_len = len;
    @(posedge clk); #1;
    bus.load_req = 1'b0;
  endtask

  // Offer every word in 'words'; gap=1 toggles in_valid 1/0 each cycle.
  task automatic stream(input logic gap, output int ndrop);
    int   idx;
    int   guard;
    logic ph;
    logic acc;
    idx = 0; guard = 0; ph = 1'b1; ndrop = 0;
    while (idx < words.size() && guard < 2000) begin
      bus.in_valid = gap ? ph : 1'b1;
      bus.in_data  = words[idx];
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (!bus.in_ready) ndrop++;
      @(posedge clk); #1;
      if (acc) idx++;
      ph = !ph;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("stream_all_accepted", idx, words.size());
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, bus.in_ready, bus.mem_we, bus.busy, bus.done, bus.err, bus.start}, 32'd0);
    chk({tag, "_addr"}, {24'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {23'd0, bus.mem_wdata}, 32'd0);
    chk({tag, "_bank"}, {30'd0, bus.mem_bank}, 32'd0);
  endtask

  initial begin
    int c0, b, d0, s0, e0, ndrop, bad, zeros;
    logic [8:0] tw[4];

    bus.load_req = 1'b0; bus.bank_sel = '0; bus.prog_len = '0; bus.abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    // Bank 0, three words back-to-back: writes on cycles +2,+3,+4, done on +5
    b = wr_q.size(); d0 = n_done; s0 = n_start;
    words = '{9'h101, 9'h0A2, 9'h1FF};
    do_load(2'd0, 9'd3, c0);
    stream(1'b0, ndrop);
    idle_cycles(4);
    chk("t1_nwr", wr_q.size() - b, 3);
    chk("t1_w0", wr_at(b + 0), {13'd0, 2'd0, 8'd0, 9'h101});
    chk("t1_w1", wr_at(b + 1), {13'd0, 2'd0, 8'd1, 9'h0A2});
    chk("t1_w2", wr_at(b + 2), {13'd0, 2'd0, 8'd2, 9'h1FF});
    for (int k = 0; k < 3; k++) chk("t1_wcyc", cyc_at(b + k) - c0, 2 + k);
    chk("t1_done_cyc", done_cyc - c0, 5);
    chk("t1_ndone", n_done - d0, 1);
    chk("t1_nstart", n_start - s0, 1);
    chk("t1_nodrop", ndrop, 0);
    chk("t1_busy_after", {31'd0, bus.busy}, 0);

    // Full bank: 256 words into bank 2, data equals address
    b = wr_q.size(); d0 = n_done;
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back(i[8:0]);
    do_load(2'd2, 9'd256, c0);
    stream(1'b0, ndrop);
    idle_cycles(4);
    bad = 0; zeros = 0;
    for (int i = 0; i < 256; i++) begin
      if (wr_at(b + i) !== {13'd0, 2'd2, i[7:0], i[8:0]}) bad++;
      if (wr_at(b + i) !== 32'hxxxxxxxx && wr_q[b + i][16:9] == 8'd0) zeros++;
    end
    chk("t2_nwr", wr_q.size() - b, 256);
    chk("t2_content_bad", bad, 0);
    chk("t2_last", wr_at(b + 255), {13'd0, 2'd2, 8'd255, 9'd255});
    chk("t2_addr0_once", zeros, 1);
    chk("t2_ndone", n_done - d0, 1);

    // Gappy upstream: valid toggles every cycle, len 4, bank 1
    b = wr_q.size(); d0 = n_done;
    tw = '{9'h055, 9'h0AA, 9'h100, 9'h0FF};
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back(tw[i]);
    do_load(2'd1, 9'd4, c0);
    stream(1'b1, ndrop);
    idle_cycles(4);
    chk("t3_nwr", wr_q.size() - b, 4);
    for (int i = 0; i < 4; i++) chk("t3_word", wr_at(b + i), {13'd0, 2'd1, i[7:0], tw[i]});
    chk("t3_ready_held", ndrop, 0);
    chk("t3_ndone", n_done - d0, 1);

    // Rejected requests: len 0, len 257, bank 3
    b = wr_q.size(); e0 = n_errp; d0 = n_done;
    do_load(2'd0, 9'd0, c0);
    idle_cycles(1);
    chk("t4_err_len0", n_errp - e0, 1);
    do_load(2'd0, 9'd257, c0);
    idle_cycles(1);
    chk("t4_err_len257", n_errp - e0, 2);
    do_load(2'd3, 9'd5, c0);
    idle_cycles(1);
    chk("t4_err_bank3", n_errp - e0, 3);
    chk("t4_idle", {31'd0, bus.busy}, 0);
    idle_cycles(3);
    chk("t4_nowr", wr_q.size() - b, 0);
    chk("t4_nodone", n_done - d0, 0);

    // Abort after the 5th accept of a 10-word load
    b = wr_q.size(); d0 = n_done; s0 = n_start;
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back(9'h010 + 9'(i));
    do_load(2'd0, 9'd10, c0);
    stream(1'b0, ndrop);
    bus.abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 9'h1AA;
    @(negedge clk);
    chk("t5_rdy_abort", {31'd0, bus.in_ready}, 0);
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    idle_cycles(4);
    chk("t5_nwr", wr_q.size() - b, 5);
    for (int i = 0; i < 5; i++) chk("t5_word", wr_at(b + i), {13'd0, 2'd0, i[7:0], 9'h010 + 9'(i)});
    chk("t5_nodone", n_done - d0, 0);
    chk("t5_nostart", n_start - s0, 0);
    chk("t5_idle", {31'd0, bus.busy}, 0);

    // Next load after abort restarts from address 0
    b = wr_q.size(); d0 = n_done;
    words = '{9'h123, 9'h045};
    do_load(2'd1, 9'd2, c0);
    stream(1'b0, ndrop);
    idle_cycles(4);
    chk("t6_nwr", wr_q.size() - b, 2);
    chk("t6_w0", wr_at(b + 0), {13'd0, 2'd1, 8'd0, 9'h123});
    chk("t6_w1", wr_at(b + 1), {13'd0, 2'd1, 8'd1, 9'h045});
    chk("t6_ndone", n_done - d0, 1);

    // Reset in the middle of an 8-word load after 3 words have been written
    b = wr_q.size(); d0 = n_done;
    words = '{9'h0C1, 9'h0C2, 9'h0C3};
    do_load(2'd0, 9'd8, c0);
    stream(1'b0, ndrop);
    idle_cycles(1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(3);
    chk("t7_nwr", wr_q.size() - b, 3);
    chk("t7_nodone", n_done - d0, 0);

    // Single-word load after reset lands at address 0
    b = wr_q.size(); d0 = n_done;
    words = '{9'h077};
    do_load(2'd0, 9'd1, c0);
    stream(1'b0, ndrop);
    idle_cycles(4);
    chk("t8_nwr", wr_q.size() - b, 1);
    chk("t8_w0", wr_at(b), {13'd0, 2'd0, 8'd0, 9'h077});
    chk("t8_ndone", n_done - d0, 1);
    chk("start_eq_done", n_sd, 0);

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
